// File: rtl/uart_tx_buffer_pkg.sv
// Shared constants for the UART transmit buffer: default depth, drain FSM states
// and the CR/LF byte values used by the optional line-ending expansion.
package uart_tx_buffer_pkg;

    localparam int UART_TX_BUF_DEPTH = 16;

    localparam logic [7:0] CR_BYTE = 8'h0D;
    localparam logic [7:0] LF_BYTE = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_SETTLE = 2'd2,
        ST_WAIT   = 2'd3
    } tx_state_e;

    function automatic logic is_lf(input logic [7:0] b);
        return b == LF_BYTE;
    endfunction

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Bus bundle between the CPU store path / transmitter (master side) and the
// transmit buffer (slave side).
interface uart_tx_buffer_if #(
    parameter int PTR_W = 4
);
    logic             cpu_wr_en;
    logic [7:0]       cpu_wr_data;
    logic             full;
    logic [PTR_W:0]   level;
    logic             overflow;
    logic             ovf_clr;
    logic             tx_wr_en;
    logic [7:0]       tx_wr_data;
    logic             tx_busy;

    modport master (
        output cpu_wr_en, cpu_wr_data, ovf_clr, tx_busy,
        input  full, level, overflow, tx_wr_en, tx_wr_data
    );

    modport slave (
        input  cpu_wr_en, cpu_wr_data, ovf_clr, tx_busy,
        output full, level, overflow, tx_wr_en, tx_wr_data
    );

endinterface

// File: rtl/uart_tx_buffer_fifo.sv
// Synchronous byte FIFO: pointer-wrapped storage with occupancy counter.
// Full/empty come from the level, so wrapped pointers never need comparing.
module uart_tx_buffer_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [PTR_W:0]   level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o    = (level_q == (PTR_W+1)'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A push while full is refused even when a pop happens in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// UART transmit buffer: FIFO between CPU stores and the serial transmitter, with
// a drain FSM pacing on tx_busy. Define UART_TX_CRLF_EN to expand LF into CR,LF.
//
// state  | meaning
// IDLE   | waiting for data and an idle transmitter
// LAUNCH | tx_wr_en pulse is on the bus
// SETTLE | transmitter is raising busy
// WAIT   | waiting for transmitter busy to drop
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int DEPTH = UART_TX_BUF_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_buffer_if.slave   bus
);

    tx_state_e      state_q, state_d;
    logic           tx_wr_en_q, tx_wr_en_d;
    logic [7:0]     tx_wr_data_q, tx_wr_data_d;
    logic           overflow_q, overflow_d;
    logic           pop;
    logic [7:0]     head;
    logic [PTR_W:0] level;
    logic           full;
    logic           empty;
`ifdef UART_TX_CRLF_EN
    logic           cr_sent_q, cr_sent_d;
`endif

    uart_tx_buffer_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (bus.cpu_wr_en),
        .wr_data_i (bus.cpu_wr_data),
        .pop_i     (pop),
        .rd_data_o (head),
        .level_o   (level),
        .full_o    (full),
        .empty_o   (empty)
    );

    assign bus.full       = full;
    assign bus.level      = level;
    assign bus.overflow   = overflow_q;
    assign bus.tx_wr_en   = tx_wr_en_q;
    assign bus.tx_wr_data = tx_wr_data_q;

    always_comb begin
        state_d      = state_q;
        tx_wr_en_d   = 1'b0;
        tx_wr_data_d = tx_wr_data_q;
        pop          = 1'b0;
`ifdef UART_TX_CRLF_EN
        cr_sent_d    = cr_sent_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!empty && !bus.tx_busy) begin
                    tx_wr_en_d = 1'b1;
                    state_d    = ST_LAUNCH;
`ifdef UART_TX_CRLF_EN
                    // LF stays at the head until its CR has gone out.
                    if (is_lf(head) && !cr_sent_q) begin
                        tx_wr_data_d = CR_BYTE;
                        cr_sent_d    = 1'b1;
                    end else begin
                        tx_wr_data_d = head;
                        pop          = 1'b1;
                        if (is_lf(head)) cr_sent_d = 1'b0;
                    end
`else
                    tx_wr_data_d = head;
                    pop          = 1'b1;
`endif
                end
            end
            ST_LAUNCH: state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!bus.tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A dropped push wins over a clear in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (bus.cpu_wr_en && full) overflow_d = 1'b1;
        else if (bus.ovf_clr)      overflow_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tx_wr_en_q   <= 1'b0;
            tx_wr_data_q <= 8'h00;
            overflow_q   <= 1'b0;
`ifdef UART_TX_CRLF_EN
            cr_sent_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tx_wr_en_q   <= tx_wr_en_d;
            tx_wr_data_q <= tx_wr_data_d;
            overflow_q   <= overflow_d;
`ifdef UART_TX_CRLF_EN
            cr_sent_q    <= cr_sent_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: directed table, hand sequences and a
// randomized run against a queue-based occupancy/stream model.
module tb_uart_tx_buffer;
    import uart_tx_buffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_buffer_if #(.PTR_W(PTR_W)) bus();

    uart_tx_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch log and expected byte stream
    logic [7:0] lq[$];
    logic [7:0] exp_q[$];

    // Random-run occupancy model
    bit model_on = 0;
    bit ovf_m    = 0;
    int acc      = 0;
    int pops     = 0;

    // Transmitter busy model
    bit busy_hold  = 0;
    bit pend       = 0;
    bit rand_frame = 0;
    int frame_len  = 0;
    int bcnt       = 0;

    int cyc         = 0;
    bit prev_en     = 0;
    int last_launch = -100;

    // Transmitter: samples wr_en on an edge, raises busy for the following frame.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (pend) begin
                pend = 0;
                bcnt = rand_frame ? int'($urandom_range(1, 12)) : frame_len;
            end
            if (busy_hold) bus.tx_busy = 1'b1;
            else if (bcnt > 0) begin
                bus.tx_busy = 1'b1;
                bcnt--;
            end else bus.tx_busy = 1'b0;
        end
    end

    // Launch monitor and per-cycle model comparison.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) prev_en = 0;
            else begin
                if (bus.tx_wr_en) begin
                    chk("busy_at_launch", int'(bus.tx_busy), 0);
                    chk("pulse_width", int'(prev_en), 0);
                    chk("spacing_ge4", int'((cyc - last_launch) >= 4), 1);
                    last_launch = cyc;
                    lq.push_back(bus.tx_wr_data);
                    pend = 1;
                    if (model_on) pops++;
                end
                prev_en = bus.tx_wr_en;
                if (model_on) begin
                    chk("rand_level", int'(bus.level), acc - pops);
                    chk("rand_full", int'(bus.full), int'((acc - pops) == DEPTH));
                    chk("rand_ovf", int'(bus.overflow), int'(ovf_m));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [7:0] d);
        tick();
        bus.cpu_wr_en   = 1'b1;
        bus.cpu_wr_data = d;
        tick();
        bus.cpu_wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (lq.size() >= exp_q.size() && bus.level == 0 && !bus.tx_busy && !pend)
                done = 1;
        end
        chk({nm, "_timeout"}, int'(done), 1);
        repeat (10) @(negedge clk);
        chk({nm, "_count"}, lq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < lq.size(); i++)
            chk({nm, "_data"}, int'(lq[i]), int'(exp_q[i]));
    endtask

    typedef struct {
        bit         push;
        logic [7:0] data;
        bit         clr;
        int         exp_level;
        bit         exp_full;
        bit         exp_ovf;
    } vec_t;

    vec_t vt[$];

    initial begin
        vec_t v;
        logic [7:0] d;
        int occ;
        bit en, clr;

        // Fill to DEPTH with busy held, then probe overflow set/clear priority.
        for (int i = 0; i < DEPTH; i++) begin
            v = '{1, 8'(8'h30 + i), 0, i + 1, (i == DEPTH - 1), 0};
            vt.push_back(v);
        end
        vt.push_back('{1, 8'h99, 0, DEPTH, 1, 1});
        vt.push_back('{0, 8'h00, 1, DEPTH, 1, 0});
        vt.push_back('{1, 8'hEE, 1, DEPTH, 1, 1});
        vt.push_back('{0, 8'h00, 1, DEPTH, 1, 0});
        vt.push_back('{0, 8'h00, 0, DEPTH, 1, 0});

        bus.cpu_wr_en   = 1'b0;
        bus.cpu_wr_data = 8'h00;
        bus.ovf_clr     = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_level", int'(bus.level), 0);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_ovf", int'(bus.overflow), 0);
        chk("rst_wr_en", int'(bus.tx_wr_en), 0);
        chk("rst_wr_data", int'(bus.tx_wr_data), 0);
        #1 rst = 1'b0;

        // Latency: strobe cycle 0 -> launch visible in cycle 2, single cycle
        lq.delete(); exp_q.delete();
        frame_len = 0;
        exp_q.push_back(8'h41);
        drive_push(8'h41);
        chk("lat_early", int'(bus.tx_wr_en), 0);
        @(negedge clk);
        chk("lat_wr_en", int'(bus.tx_wr_en), 1);
        chk("lat_data", int'(bus.tx_wr_data), 8'h41);
        @(negedge clk);
        chk("lat_pulse_end", int'(bus.tx_wr_en), 0);
        wait_drain("lat");

        // Back-to-back burst with a slow transmitter
        lq.delete(); exp_q.delete();
        frame_len = 100;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.cpu_wr_en   = 1'b1;
            bus.cpu_wr_data = 8'(8'h41 + i);
            exp_q.push_back(8'(8'h41 + i));
            tick();
        end
        bus.cpu_wr_en = 1'b0;
        wait_drain("abc");

        // Overflow table with transmitter held busy
        lq.delete(); exp_q.delete();
        busy_hold = 1;
        tick();
        for (int i = 0; i < vt.size(); i++) begin
            bus.cpu_wr_en   = vt[i].push;
            bus.cpu_wr_data = vt[i].data;
            bus.ovf_clr     = vt[i].clr;
            @(negedge clk);
            chk("tbl_level", int'(bus.level), vt[i].exp_level);
            chk("tbl_full", int'(bus.full), int'(vt[i].exp_full));
            chk("tbl_ovf", int'(bus.overflow), int'(vt[i].exp_ovf));
            #1;
        end
        bus.cpu_wr_en = 1'b0;
        bus.ovf_clr   = 1'b0;
        chk("tbl_no_launch", lq.size(), 0);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(8'h30 + i));
        frame_len = 3;
        busy_hold = 0;
        wait_drain("ovf_drain");

        // Line feed handling
        lq.delete(); exp_q.delete();
        frame_len = 4;
`ifdef UART_TX_CRLF_EN
        exp_q.push_back(CR_BYTE);
`endif
        exp_q.push_back(LF_BYTE);
        drive_push(LF_BYTE);
        wait_drain("lf");

        // Randomized traffic against the occupancy/stream model
        lq.delete(); exp_q.delete();
        acc = 0; pops = 0; ovf_m = 0;
        rand_frame = 1;
        tick();
        model_on = 1;
        for (int n = 0; n < 400; n++) begin
            occ = acc - pops;
            en  = ($urandom_range(0, 99) < 40);
            clr = ($urandom_range(0, 99) < 5);
            do d = 8'($urandom_range(0, 255));
            while (d == LF_BYTE || d == CR_BYTE);
            if (en && occ < DEPTH) begin
                acc++;
                exp_q.push_back(d);
            end
            if (en && occ >= DEPTH) ovf_m = 1;
            else if (clr)           ovf_m = 0;
            bus.cpu_wr_en   = en;
            bus.cpu_wr_data = d;
            bus.ovf_clr     = clr;
            tick();
        end
        bus.cpu_wr_en = 1'b0;
        bus.ovf_clr   = 1'b0;
        wait_drain("rand");
        model_on   = 0;
        rand_frame = 0;

        // Reset while waiting on a frame with five bytes queued
        lq.delete(); exp_q.delete();
        frame_len = 40;
        tick();
        for (int i = 0; i < 6; i++) begin
            bus.cpu_wr_en   = 1'b1;
            bus.cpu_wr_data = 8'(8'h50 + i);
            tick();
        end
        bus.cpu_wr_en = 1'b0;
        for (int i = 0; i < 20 && lq.size() == 0; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        chk("rst_pre_level", int'(bus.level), 5);
        chk("rst_pre_launches", lq.size(), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_level", int'(bus.level), 0);
        chk("rst_mid_wr_en", int'(bus.tx_wr_en), 0);
        chk("rst_mid_full", int'(bus.full), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (150) @(negedge clk);
        chk("rst_post_launches", lq.size(), 1);
        chk("rst_post_level", int'(bus.level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
